bin2bcd_digits: RTL and testbench

BIN2BCD_DIGITS -- requirements
Module: bin2bcd_digits

---
 rtl/bin2bcd_digits_pkg.sv | 15 +
 rtl/bcd_adjust.sv | 10 +
 rtl/bin2bcd_digits.sv | 146 ++++++++++++++
 tb/tb_bin2bcd_digits.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_digits_pkg.sv
// Shared codes, limits and FSM encoding for the binary-to-BCD
// display digit converter.
package bin2bcd_digits_pkg;

    localparam logic [4:0]  CODE_DASH   = 5'd22;
    localparam logic [4:0]  CODE_BLANK  = 5'd23;
    localparam logic [31:0] MAX_DISPLAY = 32'd99_999_999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_adjust (
    input  logic [3:0] nib,
    output logic [3:0] adj
);

    assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bin2bcd_digits.sv
// Sequential double-dabble converter producing eight seven-segment
// display codes, with optional leading-zero blanking and overflow dashes.
module bin2bcd_digits
    import bin2bcd_digits_pkg::*;
#(
    parameter int BIN_WIDTH     = 27,
    parameter bit BLANK_LEADING = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [4:0]           d0,
    output logic [4:0]           d1,
    output logic [4:0]           d2,
    output logic [4:0]           d3,
    output logic [4:0]           d4,
    output logic [4:0]           d5,
    output logic [4:0]           d6,
    output logic [4:0]           d7
);

    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [4:0] RST_HI = BLANK_LEADING ? CODE_BLANK : 5'd0;

    if (BIN_WIDTH < 4 || BIN_WIDTH > 27) begin : g_bad_width
        $error("bin2bcd_digits: BIN_WIDTH must be in 4..27");
    end

    state_t               state;
    state_t               state_nx;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [31:0]          bcd_q;
    logic [31:0]          bcd_adj;
    logic [CW-1:0]        cnt_q;
    logic                 ovf_q;
    logic                 last_shift;
    logic [4:0]           code  [8];
    logic [4:0]           dig_q [8];
    logic                 overflow_q;
    logic                 done_q;

    for (genvar g = 0; g < 8; g++) begin : g_adj
        bcd_adjust u_adj (
            .nib (bcd_q[4*g +: 4]),
            .adj (bcd_adj[4*g +: 4])
        );
    end

    assign last_shift = (cnt_q == CW'(BIN_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last_shift) state_nx = BLANK;
            BLANK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Scan from the top digit down; blanking stops at the first nonzero.
    always_comb begin
        logic       lead;
        logic [3:0] nib;
        lead = BLANK_LEADING;
        nib  = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
            if (ovf_q) begin
                code[i] = CODE_DASH;
            end else if (lead && nib == 4'd0 && i != 0) begin
                code[i] = CODE_BLANK;
            end else begin
                code[i] = {1'b0, nib};
                lead    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            dig_q[0]   <= 5'd0;
            for (int i = 1; i < 8; i++) begin
                dig_q[i] <= RST_HI;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q <= bin;
                        bcd_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= (32'(bin) > MAX_DISPLAY);
                    end
                end
                SHIFT: begin
                    // A carry out of the top nibble also means overflow.
                    bcd_q <= {bcd_adj[30:0], bin_q[BIN_WIDTH-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    ovf_q <= ovf_q | bcd_adj[31];
                end
                BLANK: begin
                    for (int i = 0; i < 8; i++) begin
                        dig_q[i] <= code[i];
                    end
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign d0       = dig_q[0];
    assign d1       = dig_q[1];
    assign d2       = dig_q[2];
    assign d3       = dig_q[3];
    assign d4       = dig_q[4];
    assign d5       = dig_q[5];
    assign d6       = dig_q[6];
    assign d7       = dig_q[7];

endmodule

// File: tb/tb_bin2bcd_digits.sv
// Directed scoreboard bench for bin2bcd_digits, with a blanking and a
// non-blanking instance sharing the same stimulus.
module tb_bin2bcd_digits;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [26:0] bin;

    logic       busy_a, done_a, ovf_a;
    logic [4:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic       busy_b, done_b, ovf_b;
    logic [4:0] b0, b1, b2, b3, b4, b5, b6, b7;
    logic [39:0] dig_a, dig_b;

    typedef struct packed {
        logic [39:0] a;
        logic [39:0] b;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [39:0] RST_A = {{7{5'd23}}, 5'd0};
    localparam logic [39:0] RST_B = 40'd0;

    always #5 clk = ~clk;

    bin2bcd_digits #(.BIN_WIDTH(27), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .d0(a0), .d1(a1), .d2(a2), .d3(a3),
        .d4(a4), .d5(a5), .d6(a6), .d7(a7)
    );

    bin2bcd_digits #(.BIN_WIDTH(27), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .d0(b0), .d1(b1), .d2(b2), .d3(b3),
        .d4(b4), .d5(b5), .d6(b6), .d7(b7)
    );

    assign dig_a = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign dig_b = {b7, b6, b5, b4, b3, b2, b1, b0};

    function automatic logic [39:0] model(input longint v, input bit blank);
        logic [4:0] d [8];
        bit         lead;
        if (v > 64'd99_999_999) return {8{5'd22}};
        for (int i = 0; i < 8; i++) begin
            d[i] = 5'(v % 10);
            v    = v / 10;
        end
        lead = blank;
        for (int i = 7; i >= 1; i--) begin
            if (lead && d[i] == 5'd0) d[i] = 5'd23;
            else lead = 1'b0;
        end
        return {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one conversion; optionally pulse start again at edge 5.
    task automatic run(input longint v, input bit poke);
        exp_t e;
        int   n;
        bit   got;
        bin   = 27'(v);
        start = 1'b1;
        sb.push_back('{a: model(v, 1'b1), b: model(v, 1'b0),
                       ovf: (v > 64'd99_999_999)});
        tick();
        start = 1'b0;
        n     = 0;
        got   = 1'b0;
        while (n < 40 && !got) begin
            if (poke && n == 4) begin
                start = 1'b1;
                bin   = 27'($urandom);
            end
            if (n == 5) start = 1'b0;
            tick();
            n++;
            if (n == 10) chk("busy_mid", 64'(busy_a), 64'd1);
            if (done_a) got = 1'b1;
        end
        chk("done_latency", 64'(n), 64'd28);
        if (got) begin
            e = sb.pop_front();
            chk("busy_at_done", 64'(busy_a), 64'd0);
            chk("done_b", 64'(done_b), 64'd1);
            chk("digits_blank", 64'(dig_a), 64'(e.a));
            chk("digits_noblank", 64'(dig_b), 64'(e.b));
            chk("overflow", 64'(ovf_a), 64'(e.ovf));
        end
    endtask

    initial begin
        int   ndone;
        exp_t last;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_digits_a", 64'(dig_a), 64'(RST_A));
        chk("rst_digits_b", 64'(dig_b), 64'(RST_B));
        reset = 1'b0;
        tick();

        // Each run starts in the previous done cycle (back-to-back).
        run(0, 1'b0);
        run(12_345_678, 1'b0);
        run(305, 1'b0);
        run(99_999_999, 1'b0);
        run(100_000_000, 1'b0);
        run(134_217_727, 1'b0);
        run(7, 1'b0);
        run(10_000_001, 1'b0);
        run(4321, 1'b1);

        // Outputs must hold with no further pulses while idle.
        last  = '{a: model(4321, 1'b1), b: model(4321, 1'b0), ovf: 1'b0};
        ndone = 0;
        repeat (32) begin
            tick();
            if (done_a) ndone++;
        end
        chk("idle_no_done", 64'(ndone), 64'd0);
        chk("hold_digits", 64'(dig_a), 64'(last.a));
        chk("hold_ovf", 64'(ovf_a), 64'd0);

        // Abort a conversion with reset at edge 10.
        bin   = 27'd999;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        chk("abort_digits_a", 64'(dig_a), 64'(RST_A));
        chk("abort_digits_b", 64'(dig_b), 64'(RST_B));
        ndone = 0;
        repeat (35) begin
            tick();
            if (done_a || done_b) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        // Reset together with start is reset only.
        reset = 1'b1;
        start = 1'b1;
        bin   = 27'd55;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 64'(busy_a), 64'd0);
        tick();
        chk("rst_start_idle", 64'(busy_a), 64'd0);

        run(305, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
